// File: rtl/rd_pipeline_tracker_if.sv
// Bundle between the decode stage and the pipeline tracker: ID-stage instruction
// fields in, registered EX/MEM/WB destination info and load-use stall out.
interface rd_pipeline_tracker_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rd;
  logic             id_rw;
  logic             id_mem_read;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             flush;

  logic [4:0]       id_ex_rs1;
  logic [4:0]       id_ex_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_rw;
  logic             id_ex_mem_read;
  logic [4:0]       ex_mem_rd;
  logic             ex_mem_rw;
  logic [4:0]       mem_wb_rd;
  logic             mem_wb_rw;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rd, id_rw, id_mem_read, id_rs1, id_rs2,
           id_uses_rs1, id_uses_rs2, flush,
    input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_rw, id_ex_mem_read,
           ex_mem_rd, ex_mem_rw, mem_wb_rd, mem_wb_rw, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rd, id_rw, id_mem_read, id_rs1, id_rs2,
           id_uses_rs1, id_uses_rs2, flush,
    output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_rw, id_ex_mem_read,
           ex_mem_rd, ex_mem_rw, mem_wb_rd, mem_wb_rw, stall, stall_count
  );
endinterface

// File: rtl/rd_pipeline_tracker.sv
// Tracks destination registers through EX/MEM/WB and raises a load-use stall
// when the ID instruction reads the register a load in EX has yet to return.
module rd_pipeline_tracker #(
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  rd_pipeline_tracker_if.slave        trk_if
);

  logic [4:0]       id_ex_rd_q,  id_ex_rd_d;
  logic [4:0]       id_ex_rs1_q, id_ex_rs1_d;
  logic [4:0]       id_ex_rs2_q, id_ex_rs2_d;
  logic             id_ex_rw_q,  id_ex_rw_d;
  logic             id_ex_mr_q,  id_ex_mr_d;
  logic [4:0]       ex_mem_rd_q;
  logic             ex_mem_rw_q;
  logic [4:0]       mem_wb_rd_q;
  logic             mem_wb_rw_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall;
  logic hit_rs1, hit_rs2;
  logic id_rd_nz;

  always_comb begin
    hit_rs1 = trk_if.id_uses_rs1 && (trk_if.id_rs1 == id_ex_rd_q);
    hit_rs2 = trk_if.id_uses_rs2 && (trk_if.id_rs2 == id_ex_rd_q);
    stall   = trk_if.id_valid && !trk_if.flush && id_ex_mr_q && id_ex_rw_q &&
              (id_ex_rd_q != 5'd0) && (hit_rs1 || hit_rs2);
  end

  // Anything not accepted into EX becomes an all-zero bubble
  always_comb begin
    id_rd_nz    = (trk_if.id_rd != 5'd0);
    id_ex_rd_d  = 5'd0;
    id_ex_rs1_d = 5'd0;
    id_ex_rs2_d = 5'd0;
    id_ex_rw_d  = 1'b0;
    id_ex_mr_d  = 1'b0;
    if (trk_if.id_valid && !trk_if.flush && !stall) begin
      id_ex_rd_d  = trk_if.id_rd;
      id_ex_rs1_d = trk_if.id_uses_rs1 ? trk_if.id_rs1 : 5'd0;
      id_ex_rs2_d = trk_if.id_uses_rs2 ? trk_if.id_rs2 : 5'd0;
      id_ex_rw_d  = trk_if.id_rw && id_rd_nz;
      id_ex_mr_d  = trk_if.id_mem_read && trk_if.id_rw && id_rd_nz;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_rd_q  <= 5'd0;
      id_ex_rs1_q <= 5'd0;
      id_ex_rs2_q <= 5'd0;
      id_ex_rw_q  <= 1'b0;
      id_ex_mr_q  <= 1'b0;
      ex_mem_rd_q <= 5'd0;
      ex_mem_rw_q <= 1'b0;
      mem_wb_rd_q <= 5'd0;
      mem_wb_rw_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      id_ex_rd_q  <= id_ex_rd_d;
      id_ex_rs1_q <= id_ex_rs1_d;
      id_ex_rs2_q <= id_ex_rs2_d;
      id_ex_rw_q  <= id_ex_rw_d;
      id_ex_mr_q  <= id_ex_mr_d;
      ex_mem_rd_q <= id_ex_rd_q;
      ex_mem_rw_q <= id_ex_rw_q;
      mem_wb_rd_q <= ex_mem_rd_q;
      mem_wb_rw_q <= ex_mem_rw_q;
      cnt_q       <= cnt_d;
    end
  end

  assign trk_if.id_ex_rs1      = id_ex_rs1_q;
  assign trk_if.id_ex_rs2      = id_ex_rs2_q;
  assign trk_if.id_ex_rd       = id_ex_rd_q;
  assign trk_if.id_ex_rw       = id_ex_rw_q;
  assign trk_if.id_ex_mem_read = id_ex_mr_q;
  assign trk_if.ex_mem_rd      = ex_mem_rd_q;
  assign trk_if.ex_mem_rw      = ex_mem_rw_q;
  assign trk_if.mem_wb_rd      = mem_wb_rd_q;
  assign trk_if.mem_wb_rw      = mem_wb_rw_q;
  assign trk_if.stall          = stall;
  assign trk_if.stall_count    = cnt_q;

endmodule

// File: tb/tb_rd_pipeline_tracker.sv
// Bench for rd_pipeline_tracker: directed hazard scenarios plus random traffic,
// two instances (16-bit and 2-bit stall counters) checked against a stage model.
module tb_rd_pipeline_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       rstn, valid, rw, mr, u1, u2, fl;
  logic [4:0] rd, rs1, rs2;

  rd_pipeline_tracker_if #(.CNT_W(16)) if_a ();
  rd_pipeline_tracker_if #(.CNT_W(2))  if_b ();

  assign if_a.id_valid = valid;  assign if_b.id_valid = valid;
  assign if_a.id_rd = rd;        assign if_b.id_rd = rd;
  assign if_a.id_rw = rw;        assign if_b.id_rw = rw;
  assign if_a.id_mem_read = mr;  assign if_b.id_mem_read = mr;
  assign if_a.id_rs1 = rs1;      assign if_b.id_rs1 = rs1;
  assign if_a.id_rs2 = rs2;      assign if_b.id_rs2 = rs2;
  assign if_a.id_uses_rs1 = u1;  assign if_b.id_uses_rs1 = u1;
  assign if_a.id_uses_rs2 = u2;  assign if_b.id_uses_rs2 = u2;
  assign if_a.flush = fl;        assign if_b.flush = fl;

  rd_pipeline_tracker #(.CNT_W(16)) dut_a (.clk(clk), .rst_n(rstn), .trk_if(if_a));
  rd_pipeline_tracker #(.CNT_W(2))  dut_b (.clk(clk), .rst_n(rstn), .trk_if(if_b));

  // Reference: one record per stage, shifted each accepted clock
  typedef struct {
    int rd; bit rw; bit mr; int rs1; int rs2;
  } stage_t;

  stage_t m_ex, m_mem, m_wb;
  int     m_cnt16, m_cnt2;

  function automatic stage_t bubble();
    stage_t b;
    b.rd = 0; b.rw = 0; b.mr = 0; b.rs1 = 0; b.rs2 = 0;
    return b;
  endfunction

  function automatic bit model_stall();
    bit dep;
    dep = (u1 && int'(rs1) == m_ex.rd) || (u2 && int'(rs2) == m_ex.rd);
    return valid && !fl && m_ex.mr && m_ex.rw && m_ex.rd != 0 && dep;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit st;
    stage_t nx;
    st = model_stall();
    if (!rstn) begin
      m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
      m_cnt16 = 0; m_cnt2 = 0;
    end else begin
      m_wb = m_mem;
      m_mem = bubble();
      m_mem.rd = m_ex.rd; m_mem.rw = m_ex.rw;
      if (st) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      nx = bubble();
      if (valid && !fl && !st) begin
        nx.rd  = int'(rd);
        nx.rw  = rw && rd != 0;
        nx.mr  = mr && rw && rd != 0;
        nx.rs1 = u1 ? int'(rs1) : 0;
        nx.rs2 = u2 ? int'(rs2) : 0;
      end
      m_ex = nx;
    end
  endtask

  task automatic check_regs();
    check("a.id_ex_rd",  32'(if_a.id_ex_rd),  32'(m_ex.rd));
    check("a.id_ex_rs1", 32'(if_a.id_ex_rs1), 32'(m_ex.rs1));
    check("a.id_ex_rs2", 32'(if_a.id_ex_rs2), 32'(m_ex.rs2));
    check("a.id_ex_rw",  32'(if_a.id_ex_rw),  32'(m_ex.rw));
    check("a.id_ex_mr",  32'(if_a.id_ex_mem_read), 32'(m_ex.mr));
    check("a.ex_mem_rd", 32'(if_a.ex_mem_rd), 32'(m_mem.rd));
    check("a.ex_mem_rw", 32'(if_a.ex_mem_rw), 32'(m_mem.rw));
    check("a.mem_wb_rd", 32'(if_a.mem_wb_rd), 32'(m_wb.rd));
    check("a.mem_wb_rw", 32'(if_a.mem_wb_rw), 32'(m_wb.rw));
    check("a.stall_count", 32'(if_a.stall_count), 32'(m_cnt16));
    check("b.id_ex_rd",  32'(if_b.id_ex_rd),  32'(m_ex.rd));
    check("b.mem_wb_rd", 32'(if_b.mem_wb_rd), 32'(m_wb.rd));
    check("b.stall_count", 32'(if_b.stall_count), 32'(m_cnt2));
  endtask

  // One clock: apply inputs mid-cycle, check stall, clock, check registers
  task automatic step(input bit r, input bit v, input int d, input bit w, input bit m,
                      input int s1, input bit f1, input int s2, input bit f2, input bit f);
    @(negedge clk);
    rstn = r; valid = v; rd = 5'(d); rw = w; mr = m;
    rs1 = 5'(s1); u1 = f1; rs2 = 5'(s2); u2 = f2; fl = f;
    #1;
    check("a.stall", 32'(if_a.stall), 32'(model_stall()));
    check("b.stall", 32'(if_b.stall), 32'(model_stall()));
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
    m_cnt16 = 0; m_cnt2 = 0;
    rstn = 0; valid = 1; rd = 5'd9; rw = 1; mr = 1; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; fl = 0;

    // Reset ignores inputs that look like a valid load
    step(0, 1, 9, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 9, 1, 1, 0, 0, 0, 0, 0);
    check("rst.id_ex_rd", 32'(if_a.id_ex_rd), 32'd0);
    check("rst.count", 32'(if_a.stall_count), 32'd0);

    // Load x5 followed by add reading x5
    step(1, 1, 5, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    valid = 1; rd = 5'd6; rw = 1; mr = 0; rs1 = 5'd5; u1 = 1; rs2 = 5'd2; u2 = 1; fl = 0;
    #1;
    check("lu.stall_hi", 32'(if_a.stall), 32'd1);
    @(posedge clk); model_edge(); #1; check_regs();
    check("lu.bubble_rd", 32'(if_a.id_ex_rd), 32'd0);
    check("lu.ex_mem_rd", 32'(if_a.ex_mem_rd), 32'd5);
    check("lu.count", 32'(if_a.stall_count), 32'd1);
    step(1, 1, 6, 1, 0, 5, 1, 2, 1, 0);
    check("lu.add_in_ex", 32'(if_a.id_ex_rd), 32'd6);
    check("lu.load_wb", 32'(if_a.mem_wb_rd), 32'd5);

    // Load to x0 is dropped as a writer and never causes a stall
    step(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    check("x0.id_ex_rw", 32'(if_a.id_ex_rw), 32'd0);
    step(1, 1, 7, 1, 0, 0, 1, 0, 1, 0);
    check("x0.ex_mem_rw", 32'(if_a.ex_mem_rw), 32'd0);
    idle();
    check("x0.mem_wb_rw", 32'(if_a.mem_wb_rw), 32'd0);

    // Flush masks a live hazard
    step(1, 1, 5, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    valid = 1; rd = 5'd6; rw = 1; mr = 0; rs1 = 5'd5; u1 = 1; rs2 = 0; u2 = 0; fl = 1;
    #1;
    check("fl.stall_lo", 32'(if_a.stall), 32'd0);
    @(posedge clk); model_edge(); #1; check_regs();
    check("fl.bubble", 32'(if_a.id_ex_rd), 32'd0);
    check("fl.count", 32'(if_a.stall_count), 32'd1);

    // Three back-to-back writers
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    check("b2b.mem_wb_rd", 32'(if_a.mem_wb_rd), 32'd1);
    check("b2b.ex_mem_rd", 32'(if_a.ex_mem_rd), 32'd2);
    check("b2b.id_ex_rd",  32'(if_a.id_ex_rd),  32'd3);
    check("b2b.rws", 32'({if_a.mem_wb_rw, if_a.ex_mem_rw, if_a.id_ex_rw}), 32'd7);

    // Reset with a full pipeline, then no stall from stale state
    step(1, 1, 4, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 8, 1, 1, 4, 1, 0, 0, 0);
    check("mid_rst.all", 32'({if_a.id_ex_rd, if_a.ex_mem_rd, if_a.mem_wb_rd, if_a.id_ex_rw,
                              if_a.ex_mem_rw, if_a.mem_wb_rw, if_a.id_ex_mem_read}), 32'd0);
    check("mid_rst.count", 32'(if_a.stall_count), 32'd0);
    @(negedge clk);
    rstn = 1; valid = 1; rd = 5'd9; rw = 1; mr = 0; rs1 = 5'd4; u1 = 1; rs2 = 0; u2 = 0; fl = 0;
    #1;
    check("mid_rst.stall", 32'(if_a.stall), 32'd0);
    @(posedge clk); model_edge(); #1; check_regs();

    // Five stall events into the 2-bit counter: saturates at 3
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 7, 1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 8, 1, 0, 0, 0, 7, 1, 0);
      check("sat.count2", 32'(if_b.stall_count), (k < 3) ? 32'(k + 1) : 32'd3);
      step(1, 1, 8, 1, 0, 0, 0, 7, 1, 0);
    end
    check("sat.count16", 32'(if_a.stall_count), 32'd5);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), 1'($urandom),
           int'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
